capture_ctrl: RTL and testbench

//  Consumer of the trigger output stream (sto_*). Stores qualified samples into a

---
 rtl/capture_ctrl.sv | 75 +++++++
 tb/tb_capture_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: ring-buffer sample capture with pre-trigger history and programmable post-trigger count
module capture_ctrl #(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int CCW = 32,
  parameter int MAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [1:0]     sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  output logic           mem_wen,
  output logic [MAW-1:0] mem_waddr,
  output logic [SDW-1:0] mem_wdata,
  output logic           sts_armed,
  output logic           sts_done,
  output logic [MAW-1:0] sts_trgaddr
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_nx;
  logic [MAW-1:0] ptr;
  logic [CCW-1:0] cnt, post_reg;
  logic wr_ctrl, arm, abort, restart, store, trig;
  assign bus_wready = 1'b1;
  assign sti_tready = 1'b1;
  assign wr_ctrl = bus_wvalid && bus_waddr == '0;
  assign arm = wr_ctrl & bus_wdata[0];
  assign abort = wr_ctrl & bus_wdata[1];
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: abort dominates, then re-arm, then trigger, then post count expiry
  always_comb
    state_nx = abort ? IDLE :
               restart ? ARMED :
               trig ? (cnt == '0 ? DONE : POST) :
               (state == POST && store && cnt == CCW'(1)) ? DONE : state;
  // state-decoded outputs and per-cycle strobes
  always_comb begin
    sts_armed = state == ARMED || state == POST;
    sts_done = state == DONE;
    restart = arm && !abort && (state == IDLE || state == DONE);
    store = sts_armed && sti_tvalid && !sti_tevent[1] && !abort;
    trig = store && sti_tevent[0] && state == ARMED;
  end
  // datapath: registered memory write, pointer, post counter, trigger address
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wen <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      ptr <= '0;
      cnt <= '0;
      post_reg <= '0;
      sts_trgaddr <= '0;
    end else begin
      mem_wen <= store;
      if (store) begin
        mem_waddr <= ptr;
        mem_wdata <= sti_tdata;
      end
      if (bus_wvalid && bus_waddr == BAW'(1)) post_reg <= bus_wdata[CCW-1:0];
      ptr <= restart ? '0 : store ? ptr + 1'b1 : ptr;
      cnt <= restart ? post_reg : (store && state == POST) ? cnt - 1'b1 : cnt;
      sts_trgaddr <= restart ? '0 : trig ? ptr : sts_trgaddr;
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed checks of capture_ctrl with a wide (MAW=12) and a tiny (MAW=2) ring
module tb_capture_ctrl;
  logic clk = 0, rst = 1;
  logic bus_wvalid = 0;
  logic [5:0] bus_waddr = 0;
  logic [31:0] bus_wdata = 0;
  logic sti_tvalid = 0;
  logic [1:0] sti_tevent = 0;
  logic [31:0] sti_tdata = 0;
  logic a_bready, a_sready, a_wen, a_armed, a_done;
  logic [11:0] a_waddr, a_trg;
  logic [31:0] a_wdata;
  logic b_bready, b_sready, b_wen, b_armed, b_done;
  logic [1:0] b_waddr, b_trg;
  logic [31:0] b_wdata;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  capture_ctrl dut_a (
    .clk(clk), .rst(rst), .bus_wready(a_bready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .sti_tready(a_sready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent),
    .sti_tdata(sti_tdata), .mem_wen(a_wen), .mem_waddr(a_waddr), .mem_wdata(a_wdata),
    .sts_armed(a_armed), .sts_done(a_done), .sts_trgaddr(a_trg));

  capture_ctrl #(.MAW(2)) dut_b (
    .clk(clk), .rst(rst), .bus_wready(b_bready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata), .sti_tready(b_sready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent),
    .sti_tdata(sti_tdata), .mem_wen(b_wen), .mem_waddr(b_waddr), .mem_wdata(b_wdata),
    .sts_armed(b_armed), .sts_done(b_done), .sts_trgaddr(b_trg));

  task automatic cyc(input logic bv, input logic [5:0] ba, input logic [31:0] bd,
                     input logic tv, input logic [1:0] te, input logic [31:0] td);
    bus_wvalid = bv; bus_waddr = ba; bus_wdata = bd;
    sti_tvalid = tv; sti_tevent = te; sti_tdata = td;
    @(posedge clk); #1;
    bus_wvalid = 0; sti_tvalid = 0; sti_tevent = 0;
  endtask

  task automatic wr(input logic [5:0] ba, input logic [31:0] bd);
    cyc(1, ba, bd, 0, 2'b00, 0);
  endtask

  task automatic beat(input logic [31:0] td, input logic [1:0] te);
    cyc(0, 0, 0, 1, te, td);
  endtask

  task automatic test_reset;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    n_cmp++; if ({a_bready, a_sready} !== 2'b11) begin n_err++; $display("FAIL reset_ready: got %b want 11", {a_bready, a_sready}); end
    n_cmp++; if ({a_wen, a_armed, a_done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {a_wen, a_armed, a_done}); end
    n_cmp++; if ({a_waddr, a_trg, a_wdata} !== '0) begin n_err++; $display("FAIL reset_regs: got %h/%h/%h want 0", a_waddr, a_trg, a_wdata); end
  endtask

  task automatic test_basic_capture;
    wr(1, 3);
    wr(0, 1);
    n_cmp++; if (a_armed !== 1'b1) begin n_err++; $display("FAIL basic_armed: got %b want 1", a_armed); end
    for (int i = 0; i < 6; i++) begin
      beat(32'(i), i == 2 ? 2'b01 : 2'b00);
      n_cmp++; if ({a_wen, a_waddr, a_wdata} !== {1'b1, 12'(i), 32'(i)}) begin n_err++; $display("FAIL basic_write%0d: got wen=%b addr=%0d data=%0d want 1/%0d/%0d", i, a_wen, a_waddr, a_wdata, i, i); end
      n_cmp++; if (a_done !== (i == 5)) begin n_err++; $display("FAIL basic_done%0d: got %b want %b", i, a_done, i == 5); end
    end
    n_cmp++; if (a_trg !== 12'd2) begin n_err++; $display("FAIL basic_trgaddr: got %0d want 2", a_trg); end
    n_cmp++; if (a_armed !== 1'b0) begin n_err++; $display("FAIL basic_disarmed: got %b want 0", a_armed); end
    beat(9, 2'b00);
    n_cmp++; if (a_wen !== 1'b0) begin n_err++; $display("FAIL done_drops: got %b want 0", a_wen); end
    n_cmp++; if ({a_done, a_trg, a_waddr, a_wdata} !== {1'b1, 12'd2, 12'd5, 32'd5}) begin n_err++; $display("FAIL done_hold: got %b/%0d/%0d/%0d want 1/2/5/5", a_done, a_trg, a_waddr, a_wdata); end
  endtask

  task automatic test_post_zero;
    wr(1, 0);
    wr(0, 1);
    n_cmp++; if ({a_armed, a_done, a_trg} !== {1'b1, 1'b0, 12'd0}) begin n_err++; $display("FAIL post0_rearm: got %b/%b/%0d want 1/0/0", a_armed, a_done, a_trg); end
    beat(7, 2'b01);
    n_cmp++; if ({a_wen, a_waddr, a_wdata, a_done} !== {1'b1, 12'd0, 32'd7, 1'b1}) begin n_err++; $display("FAIL post0_write: got %b/%0d/%0d/%b want 1/0/7/1", a_wen, a_waddr, a_wdata, a_done); end
    beat(8, 2'b00);
    n_cmp++; if (a_wen !== 1'b0) begin n_err++; $display("FAIL post0_single: got %b want 0", a_wen); end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_a [9];
    exp_a = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    wr(1, 2);
    wr(0, 1);
    for (int i = 0; i < 9; i++) begin
      beat(32'(100 + i), i == 6 ? 2'b01 : 2'b00);
      n_cmp++; if ({b_wen, b_waddr, b_wdata} !== {1'b1, exp_a[i], 32'(100 + i)}) begin n_err++; $display("FAIL wrap_write%0d: got %b/%0d/%0d want 1/%0d/%0d", i, b_wen, b_waddr, b_wdata, exp_a[i], 100 + i); end
    end
    n_cmp++; if ({b_trg, b_done} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL wrap_status: got trg=%0d done=%b want 2/1", b_trg, b_done); end
  endtask

  task automatic test_discard;
    wr(1, 5);
    wr(0, 1);
    for (int i = 0; i < 3; i++) begin
      beat(32'(50 + i), i == 2 ? 2'b10 : 2'b11);
      n_cmp++; if ({a_wen, a_armed, a_done, a_trg} !== {1'b0, 1'b1, 1'b0, 12'd0}) begin n_err++; $display("FAIL discard%0d: got wen=%b armed=%b done=%b trg=%0d want 0/1/0/0", i, a_wen, a_armed, a_done, a_trg); end
    end
    beat(60, 2'b00);
    n_cmp++; if ({a_wen, a_waddr, a_wdata} !== {1'b1, 12'd0, 32'd60}) begin n_err++; $display("FAIL discard_ptr: got %b/%0d/%0d want 1/0/60", a_wen, a_waddr, a_wdata); end
  endtask

  task automatic test_abort;
    beat(61, 2'b01);
    n_cmp++; if ({a_wen, a_waddr, a_trg, a_armed} !== {1'b1, 12'd1, 12'd1, 1'b1}) begin n_err++; $display("FAIL abort_pre: got %b/%0d/%0d/%b want 1/1/1/1", a_wen, a_waddr, a_trg, a_armed); end
    cyc(1, 0, 2, 1, 2'b01, 62);
    n_cmp++; if ({a_wen, a_armed, a_done} !== 3'b000) begin n_err++; $display("FAIL abort_same_cycle: got %b want 000", {a_wen, a_armed, a_done}); end
    cyc(1, 0, 1, 1, 2'b00, 63);
    n_cmp++; if ({a_wen, a_armed, a_trg} !== {1'b0, 1'b1, 12'd0}) begin n_err++; $display("FAIL arm_beat_dropped: got %b/%b/%0d want 0/1/0", a_wen, a_armed, a_trg); end
    beat(64, 2'b00);
    n_cmp++; if ({a_wen, a_waddr, a_wdata} !== {1'b1, 12'd0, 32'd64}) begin n_err++; $display("FAIL rearm_addr0: got %b/%0d/%0d want 1/0/64", a_wen, a_waddr, a_wdata); end
    wr(0, 3);
    n_cmp++; if ({a_armed, a_done} !== 2'b00) begin n_err++; $display("FAIL arm_abort_wins: got %b want 00", {a_armed, a_done}); end
    beat(65, 2'b00);
    n_cmp++; if (a_wen !== 1'b0) begin n_err++; $display("FAIL idle_drops: got %b want 0", a_wen); end
  endtask

  task automatic test_reset_mid;
    wr(0, 1);
    beat(70, 2'b01);
    beat(71, 2'b00);
    n_cmp++; if ({a_armed, a_wen, a_waddr} !== {1'b1, 1'b1, 12'd1}) begin n_err++; $display("FAIL mid_post: got %b/%b/%0d want 1/1/1", a_armed, a_wen, a_waddr); end
    rst = 1;
    beat(72, 2'b00);
    rst = 0;
    n_cmp++; if ({a_wen, a_armed, a_done, a_bready, a_sready} !== 5'b00011) begin n_err++; $display("FAIL mid_reset_flags: got %b want 00011", {a_wen, a_armed, a_done, a_bready, a_sready}); end
    n_cmp++; if ({a_waddr, a_trg, a_wdata} !== '0) begin n_err++; $display("FAIL mid_reset_regs: got %h/%h/%h want 0", a_waddr, a_trg, a_wdata); end
    n_cmp++; if ({b_wen, b_armed, b_done, b_trg} !== '0) begin n_err++; $display("FAIL mid_reset_b: got %b/%b/%b/%0d want 0", b_wen, b_armed, b_done, b_trg); end
    wr(0, 1);
    beat(73, 2'b01);
    n_cmp++; if ({a_wen, a_waddr, a_done} !== {1'b1, 12'd0, 1'b1}) begin n_err++; $display("FAIL post_cleared: got %b/%0d/%b want 1/0/1", a_wen, a_waddr, a_done); end
  endtask

  initial begin
    test_reset;
    test_basic_capture;
    test_post_zero;
    test_wrap;
    test_discard;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
